// File: rtl/ring_game_pkg.sv
// Shared types and constants for the ring reaction game.
package ring_game_pkg;

  localparam int         RING_WIDTH  = 15;
  localparam logic [3:0] INVALID_POS = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Verdict on the ring value seen on a press cycle.
  typedef struct packed {
    logic       hit;
    logic       miss;
    logic       bad;
    logic [3:0] pos;
  } judge_t;

endpackage

// File: rtl/onehot_encode.sv
// One-hot to binary index. valid is low for zero or multi-hot input.
module onehot_encode #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0]         onehot,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     valid
);

  localparam int IW = $clog2(WIDTH);

  // OR together the indices of every set bit; only meaningful when valid.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
    valid = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/ring_stop_judge.sv
// Reaction-game judge: gates the ring counter, catches stop presses,
// scores the captured position over a fixed number of rounds.
module ring_stop_judge
  import ring_game_pkg::*;
#(
  parameter int WIDTH       = RING_WIDTH,
  parameter int TARGET      = 7,
  parameter int ROUNDS      = 5,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tick,
  input  logic             stop_btn,
  input  logic [WIDTH-1:0] count,
  output logic             ring_en,
  output logic             hit,
  output logic             miss,
  output logic [3:0]       pos,
  output logic [3:0]       score,
  output logic [3:0]       round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);
  localparam int HW = $clog2(HOLD_CYCLES);

  state_t        state, state_nxt;
  logic          sync1, sync_q, prev_q;
  logic          stop_edge;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] enc_idx;
  logic          enc_valid;
  judge_t        jd;
  logic          cap;
  logic          clr_game;

  onehot_encode #(.WIDTH(WIDTH)) u_enc (
    .onehot (count),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  // Two-flop synchroniser plus a delayed copy for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync1  <= stop_btn;
      sync_q <= sync1;
      prev_q <= sync_q;
    end
  end

  assign stop_edge = sync_q & ~prev_q;
  assign cap       = (state == RUN) & stop_edge;
  assign clr_game  = start & ((state == IDLE) | (state == DONE));

  // Ring only moves while running, and never on the press cycle so the
  // capture sees the pre-advance value.
  assign ring_en = tick & (state == RUN) & ~stop_edge;
  assign busy    = (state == RUN) | (state == HOLD);
  assign done    = (state == DONE);

  // Classify the ring value presented on the press cycle.
  always_comb begin
    jd.bad  = ~enc_valid;
    jd.hit  = enc_valid && (enc_idx == IW'(TARGET));
    jd.miss = ~jd.hit;
    jd.pos  = enc_valid ? 4'(enc_idx) : INVALID_POS;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start only honoured from IDLE/DONE, presses only in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (stop_edge) state_nxt = HOLD;
      HOLD: if (hold_cnt == '0) state_nxt = (round == 4'(ROUNDS)) ? DONE : RUN;
      DONE: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Freeze timer: loaded on capture, counts down to zero through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               hold_cnt <= '0;
    else if (cap)                             hold_cnt <= HW'(HOLD_CYCLES - 1);
    else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
  end

  // Score/round bookkeeping and one-cycle verdict pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit   <= 1'b0;
      miss  <= 1'b0;
      pos   <= INVALID_POS;
      score <= '0;
      round <= '0;
      err   <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (clr_game) begin
        score <= '0;
        round <= '0;
        err   <= 1'b0;
      end
      if (cap) begin
        hit   <= jd.hit;
        miss  <= jd.miss;
        pos   <= jd.pos;
        round <= round + 4'd1;
        if (jd.hit && score != 4'hF) score <= score + 4'd1;
        if (jd.bad) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_stop_judge.sv
// Directed bench for ring_stop_judge with a short hold window.
module tb_ring_stop_judge;
  import ring_game_pkg::*;

  localparam int WIDTH = 15;
  localparam int HOLD  = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, tick, stop_btn;
  logic [WIDTH-1:0] count;
  logic             ring_en, hit, miss, busy, done, err;
  logic [3:0]       pos, score, round;

  int vecs = 0;
  int errs = 0;
  int pulses;

  ring_stop_judge #(
    .WIDTH(WIDTH), .TARGET(7), .ROUNDS(5), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .stop_btn(stop_btn), .count(count), .ring_en(ring_en),
    .hit(hit), .miss(miss), .pos(pos), .score(score), .round(round),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raw rise now; stop_edge visible after two edges, capture on the third.
  task automatic press(input logic [WIDTH-1:0] cv);
    count    = cv;
    stop_btn = 1'b1;
    step();
    check("run_en", 16'(ring_en), 16'd1);
    step();
    check("edge_gate", 16'(ring_en), 16'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tick = 1'b1; stop_btn = 1'b0; count = 15'h0001;
    #12;
    check("rst_busy",  16'(busy),    16'd0);
    check("rst_done",  16'(done),    16'd0);
    check("rst_pos",   16'(pos),     16'hF);
    check("rst_score", 16'(score),   16'd0);
    check("rst_round", 16'(round),   16'd0);
    check("rst_en",    16'(ring_en), 16'd0);
    check("rst_err",   16'(err),     16'd0);
    rst_n = 1'b1;
    step();
    check("idle_en", 16'(ring_en), 16'd0);

    start = 1'b1; step(); start = 1'b0;
    check("start_busy", 16'(busy),    16'd1);
    check("start_en",   16'(ring_en), 16'd1);

    // Hit on bit 7 with tick coincident with the press edge.
    press(15'h0080);
    stop_btn = 1'b0;
    check("hit_pulse", 16'(hit),   16'd1);
    check("hit_miss",  16'(miss),  16'd0);
    check("hit_pos",   16'(pos),   16'd7);
    check("hit_score", 16'(score), 16'd1);
    check("hit_round", 16'(round), 16'd1);
    check("hold_en0",  16'(ring_en), 16'd0);
    for (int i = 0; i < HOLD - 1; i++) begin
      step();
      check("hold_en", 16'(ring_en), 16'd0);
      check("hit_once", 16'(hit), 16'd0);
    end
    step();
    check("resume_en", 16'(ring_en), 16'd1);

    // Valid miss.
    press(15'h0001);
    stop_btn = 1'b0;
    check("miss_pulse", 16'(miss),  16'd1);
    check("miss_pos",   16'(pos),   16'd0);
    check("miss_score", 16'(score), 16'd1);
    check("miss_err",   16'(err),   16'd0);
    repeat (HOLD) step();

    // Multi-hot capture.
    press(15'h0003);
    stop_btn = 1'b0;
    check("inv_miss",  16'(miss),  16'd1);
    check("inv_pos",   16'(pos),   16'hF);
    check("inv_err",   16'(err),   16'd1);
    check("inv_round", 16'(round), 16'd3);
    repeat (HOLD) step();

    // Held button: 20 cycles high gives exactly one capture.
    count = 15'h0080; stop_btn = 1'b1; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(hit | miss);
    end
    check("held_once",  16'(pulses), 16'd1);
    check("held_round", 16'(round),  16'd4);
    check("held_score", 16'(score),  16'd2);
    stop_btn = 1'b0;
    repeat (3) step();

    // Last round; re-press inside HOLD must be ignored.
    press(15'h0001);
    check("r5_miss", 16'(miss), 16'd1);
    stop_btn = 1'b0; step();
    stop_btn = 1'b1; pulses = 0;
    for (int i = 0; i < HOLD - 1; i++) begin
      step();
      pulses += int'(hit | miss);
    end
    check("hold_ignore", 16'(pulses), 16'd0);
    check("g1_round",    16'(round),  16'd5);
    check("g1_done",     16'(done),   16'd1);
    check("g1_busy",     16'(busy),   16'd0);
    check("g1_score",    16'(score),  16'd2);
    check("done_en",     16'(ring_en), 16'd0);

    // Restart clears the game.
    start = 1'b1; step(); start = 1'b0; stop_btn = 1'b0;
    check("rs_busy",  16'(busy),  16'd1);
    check("rs_done",  16'(done),  16'd0);
    check("rs_score", 16'(score), 16'd0);
    check("rs_round", 16'(round), 16'd0);
    check("rs_err",   16'(err),   16'd0);
    repeat (3) step();

    // Full game of five hits.
    for (int r = 0; r < 5; r++) begin
      press(15'h0080);
      stop_btn = 1'b0;
      check("g2_hit", 16'(hit), 16'd1);
      repeat (HOLD) step();
    end
    check("g2_done",  16'(done),  16'd1);
    check("g2_score", 16'(score), 16'd5);
    check("g2_round", 16'(round), 16'd5);
    check("g2_busy",  16'(busy),  16'd0);

    start = 1'b1; step(); start = 1'b0;
    check("g3_busy",  16'(busy),  16'd1);
    check("g3_score", 16'(score), 16'd0);
    check("g3_round", 16'(round), 16'd0);
    check("g3_err",   16'(err),   16'd0);

    // Reset mid-HOLD takes effect without a clock edge.
    press(15'h0001);
    stop_btn = 1'b0;
    step();
    check("pre_rst_busy", 16'(busy), 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_busy",  16'(busy),    16'd0);
    check("ar_score", 16'(score),   16'd0);
    check("ar_round", 16'(round),   16'd0);
    check("ar_pos",   16'(pos),     16'hF);
    check("ar_en",    16'(ring_en), 16'd0);
    check("ar_done",  16'(done),    16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ring_stop_judge.md
# ring_stop_judge

Reaction-game judge sitting directly downstream of the 15-bit one-hot ring counter. It gates the counter's advance enable and synchronises and edge-detects the player's stop button. On each press it freezes the ring and captures the lit position, then scores it against a target position over a fixed number of rounds. Its outputs feed the score display and the LED/result indicators.

## Interface
- WIDTH, 15, ring length; count is one-hot over WIDTH bits
- TARGET, 7, bit index that counts as a hit (0..WIDTH-1)
- ROUNDS, 5, presses per game (1..15)
- HOLD_CYCLES, 50_000_000, clk cycles the ring stays frozen after a press (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  synchronous one-cycle start/restart strobe
- tick  in  1  one-cycle advance strobe from the prescaler
- stop_btn  in  1  raw asynchronous push-button level, active-high
- count  in  WIDTH  current ring-counter value
- ring_en  out  1  enable to ring counter, combinational
- hit  out  1  one-cycle pulse: press landed on TARGET
- miss  out  1  one-cycle pulse: press missed
- pos  out  4  captured bit index of last press; 4'hF if capture invalid
- score  out  4  hits this game, saturating at 15
- round  out  4  presses completed this game
- busy  out  1  high in RUN or HOLD
- done  out  1  high in DONE
- err  out  1  sticky: a non-one-hot count was captured this game

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset: state IDLE, all registered outputs 0, except pos = 4'hF. Sync flops, edge register and hold counter are cleared.
- IDLE → RUN on start. Entering RUN from IDLE or DONE clears score, round and err.
- ring_en = tick & (state==RUN) & ~stop_edge. The ring never advances outside RUN or on a press cycle.
- stop_btn passes through a 2-flop synchroniser. stop_edge = sync_q & ~prev_q. Only rising edges count; holding the button does not re-trigger.
- RUN with stop_edge:
  - count is captured and encoded to pos.
  - count == (1<<TARGET) → hit; any other valid one-hot value → miss.
  - count zero or multi-hot → miss, pos = 4'hF, err set.
  - round increments. On a hit, score increments, saturating.
  - The hold counter loads HOLD_CYCLES-1 and the block moves to HOLD.
- HOLD: the counter decrements each cycle; stop edges are ignored. At counter 0: round==ROUNDS → DONE, else → RUN.
- DONE: done held high until start, which clears the game and moves to RUN.
- start in RUN or HOLD is ignored.
- A tick coincident with stop_edge: the capture uses the pre-advance count and ring_en stays 0 that cycle.
- Reset asserted mid-game returns everything to reset values immediately. The block does not reset the ring counter.

## Timing
- stop_btn rising before edge k makes stop_edge high in the cycle after edge k+1. Capture happens on edge k+2.
- hit/miss/pos/score/round are registered. They update on the capture edge, and hit or miss stays high for exactly the following cycle.
- HOLD lasts exactly HOLD_CYCLES cycles. ring_en may next assert HOLD_CYCLES cycles after the capture edge.
- done rises on the edge that ends the last HOLD. start is accepted on the edge where it is sampled high.

## Structure
- Shared package ring_game_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3)
  - RING_WIDTH = 15
  - INVALID_POS = 4'hF
- Sub-module onehot_encode (WIDTH parameter): combinational one-hot → index plus a valid flag. valid is 0 for zero or multiple bits set.
- Synchroniser, edge detect, FSM, hold counter and score/round registers are inline in ring_stop_judge.

## Test plan
- Reset: assert rst_n=0 mid-HOLD → state IDLE, score=0, round=0, pos=4'hF, ring_en=0, done=0, all asynchronously.
- Hit: start, drive count=15'h0080 (bit 7), pulse stop_btn → pos=7, hit pulse for 1 cycle 3 edges after the raw rise, score=1, round=1, ring_en=0 for HOLD_CYCLES (set HOLD_CYCLES=4 in bench).
- Miss and invalid:
  - count=15'h0001 press → miss, pos=0, score unchanged.
  - count=15'h0003 press → miss, pos=4'hF, err=1.
- Tick coincident with stop_edge → ring_en=0 that cycle, pos = pre-advance index.
- Held button: stop_btn high for 20 cycles → exactly one capture; presses during HOLD → no hit/miss, round unchanged.
- Full game: ROUNDS=5 with 5 hits → done=1, score=5, round=5, busy=0. Then start → score=0, round=0, err=0, state RUN.
